lsu_access_ctrl: RTL and testbench

Memory-access controller of the MA-stage load/store unit. It accepts one load or store request at a time from the MA pipeline register and runs a single access to the word-organised data memory. It produces per-byte write enables, lane-replicated store data, and a returned load value that is aligned and sign/zero-extended. It reports misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/decoder_2to4.sv | 19 +
 rtl/lsu_load_extend.sv | 35 +++
 rtl/lsu_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the MA-stage load/store access controller:
//   - RISC-V funct3 size/sign codes for loads and stores
//   - access-controller FSM state encodings
//   - byte-enable patterns
//   - captured-request record and the access fault check
// -----------------------------------------------------------------------------
package lsu_pkg;

  // Load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Byte-enable patterns for halfword/word accesses
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Request fields held for the duration of one access
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } lsu_req_t;

  // Misaligned halfword/word, reserved size codes, or an unsigned-size store.
  function automatic logic req_fault(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic f;
    f = 1'b0;
    case (funct3)
      3'b001, 3'b101:         f = off[0];
      3'b010:                 f = |off;
      3'b011, 3'b110, 3'b111: f = 1'b1;
      default:                f = 1'b0;
    endcase
    if (we && funct3[2]) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/decoder_2to4.sv
// -----------------------------------------------------------------------------
// decoder_2to4
// Binary-to-one-hot decoder used for byte-lane selection.
//   i_sel    : 2-bit lane index
//   o_onehot : one-hot lane mask (00 -> 0001 ... 11 -> 1000)
// -----------------------------------------------------------------------------
module decoder_2to4 (
  input  logic [1:0] i_sel,
  output logic [3:0] o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign o_onehot[gi] = (i_sel == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/lsu_load_extend.sv
// -----------------------------------------------------------------------------
// lsu_load_extend
// Aligns a memory read word to the addressed byte and applies the load
// size/sign extension.
//   i_rdata    : raw memory word
//   i_byte_off : byte offset within the word (addr[1:0])
//   i_funct3   : load size/sign code
//   o_data     : aligned, extended load value (0 for non-load codes)
// -----------------------------------------------------------------------------
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_byte_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_byte_off, 3'b000};

  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      LB:      o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LBU:     o_data = {24'h0, w_shifted[7:0]};
      LH:      o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LHU:     o_data = {16'h0, w_shifted[15:0]};
      LW:      o_data = w_shifted;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_access_ctrl
// MA-stage memory-access controller. Accepts one load/store at a time, runs a
// single access to word-organised data memory, and returns an aligned,
// extended load value or a fault flag.
//   i_clk, i_reset                 : clock, asynchronous active-high reset
//   i_req_valid / o_req_ready      : request handshake (ready only in IDLE)
//   i_req_we, i_req_addr,
//   i_req_funct3, i_req_wdata      : request fields
//   o_rsp_valid                    : one-cycle completion pulse
//   o_rsp_rdata                    : extended load data (0 for stores/faults)
//   o_rsp_misaligned               : fault flag, qualified by o_rsp_valid
//   o_mem_en/we/addr/be/wdata      : memory strobe, write, word address,
//                                    byte enables, lane-replicated store data
//   i_mem_rdata                    : memory read word, valid MEM_LAT cycles
//                                    after the enable cycle
// -----------------------------------------------------------------------------
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1    // 1..3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_addr,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_misaligned,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  logic [1:0]        r_state;
  lsu_req_t          r_req;
  logic [ADDR_W+1:0] r_addr;
  logic [1:0]        r_cnt;
  logic              r_fault;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_fault;
  logic              w_access;
  logic [3:0]        w_lane;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ext;
  logic              w_unused_addr_hi;

  // Address bits above the memory range are deliberately dropped.
  assign w_unused_addr_hi = ^i_req_addr[31:ADDR_W+2];

  assign o_req_ready = (r_state == ST_IDLE);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_fault     = req_fault(i_req_we, i_req_funct3, i_req_addr[1:0]);
  assign w_access    = (r_state == ST_ACCESS);

  decoder_2to4 u_lane_dec (
    .i_sel    (r_addr[1:0]),
    .o_onehot (w_lane)
  );

  lsu_load_extend u_load_ext (
    .i_rdata    (i_mem_rdata),
    .i_byte_off (r_addr[1:0]),
    .i_funct3   (r_req.funct3),
    .o_data     (w_ext)
  );

  // Size codes 11 never reach ACCESS (they fault), so default covers word.
  always_comb begin
    case (r_req.funct3[1:0])
      2'b00:   w_be = w_lane;
      2'b01:   w_be = r_addr[1] ? BE_HALF_HI : BE_HALF_LO;
      default: w_be = BE_WORD;
    endcase
  end

  // Each byte lane picks the store byte it would carry for the access size.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wdata[8*gi +: 8] =
        (r_req.funct3[1:0] == 2'b00) ? r_req.wdata[7:0] :
        (r_req.funct3[1:0] == 2'b01) ? r_req.wdata[8*(gi%2) +: 8] :
                                       r_req.wdata[8*gi +: 8];
    end
  endgenerate

  // Memory outputs are decoded from ACCESS so they drop with reset at once.
  assign o_mem_en    = w_access;
  assign o_mem_we    = w_access & r_req.we;
  assign o_mem_addr  = w_access ? r_addr[ADDR_W+1:2] : '0;
  assign o_mem_be    = w_access ? w_be : 4'b0000;
  assign o_mem_wdata = w_access ? w_wdata : 32'h0;

  assign o_rsp_valid      = (r_state == ST_RESP);
  assign o_rsp_misaligned = (r_state == ST_RESP) & r_fault;
  assign o_rsp_rdata      = r_rdata;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req.we     <= i_req_we;
            r_req.funct3 <= i_req_funct3;
            r_req.wdata  <= i_req_wdata;
            r_addr       <= i_req_addr[ADDR_W+1:0];
            r_fault      <= w_fault;
            if (w_fault) begin
              r_rdata <= '0;
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (r_req.we) begin
            r_rdata <= '0;
            r_state <= ST_RESP;
          end else begin
            r_cnt   <= LAT_INIT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_rdata <= w_ext;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: r_state <= ST_IDLE;  // ST_RESP
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_access_ctrl
// Two controllers (MEM_LAT=1 and MEM_LAT=3) share the request inputs; each has
// its own read-latency model of a small data memory.
// -----------------------------------------------------------------------------
module tb_lsu_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;

  logic [1:0]  ready, rsp_valid, rsp_mis, mem_en, mem_we;
  logic [31:0] rsp_rdata [2];
  logic [9:0]  mem_addr  [2];
  logic [3:0]  mem_be    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] mem  [16];
  logic [31:0] pipe [2][3];

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_access_ctrl #(.ADDR_W(10), .MEM_LAT(1)) u_lat1 (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(ready[0]),
    .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_funct3(req_funct3), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]),
    .o_rsp_misaligned(rsp_mis[0]),
    .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
    .o_mem_be(mem_be[0]), .o_mem_wdata(mem_wdata[0]),
    .i_mem_rdata(mem_rdata[0])
  );

  lsu_access_ctrl #(.ADDR_W(10), .MEM_LAT(3)) u_lat3 (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(ready[1]),
    .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_funct3(req_funct3), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]),
    .o_rsp_misaligned(rsp_mis[1]),
    .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
    .o_mem_be(mem_be[1]), .o_mem_wdata(mem_wdata[1]),
    .i_mem_rdata(mem_rdata[1])
  );

  // Read data is valid only in the cycle MEM_LAT after the enable cycle;
  // otherwise the bus carries a marker word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mem
    always @(posedge clk) begin
      pipe[gi][0] <= (mem_en[gi] && !mem_we[gi]) ? mem[mem_addr[gi][3:0]] : 32'hDEAD_BEEF;
      pipe[gi][1] <= pipe[gi][0];
      pipe[gi][2] <= pipe[gi][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [9:0]  maddr;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic run_vec(input int idx, input vec_t v);
    int          en_cnt [2], en_cyc [2], rsp_cnt [2], rsp_cyc [2], rdy_bad [2];
    logic [3:0]  be_s [2];
    logic [31:0] wd_s [2], rd_s [2];
    logic [9:0]  ma_s [2];
    logic        we_s [2], mis_s [2];
    int          lat, exp_rsp;
    string       tag;
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0; en_cyc[d] = 0; rsp_cnt[d] = 0; rsp_cyc[d] = 0; rdy_bad[d] = 0;
      be_s[d] = '0; wd_s[d] = '0; rd_s[d] = '0; ma_s[d] = '0; we_s[d] = 0; mis_s[d] = 0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_funct3 = v.f3; req_wdata = v.wdata;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ready[d] && rsp_cnt[d] == 0) rdy_bad[d]++;
        if (mem_en[d]) begin
          en_cnt[d]++; en_cyc[d] = k;
          be_s[d] = mem_be[d]; wd_s[d] = mem_wdata[d];
          ma_s[d] = mem_addr[d]; we_s[d] = mem_we[d];
        end
        if (rsp_valid[d]) begin
          rsp_cnt[d]++; rsp_cyc[d] = k;
          rd_s[d] = rsp_rdata[d]; mis_s[d] = rsp_mis[d];
        end
      end
      req_valid = 1'b0;
    end
    n_vec++;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      exp_rsp = v.fault ? 1 : (v.we ? 2 : 2 + lat);
      tag = $sformatf("v%0d/lat%0d", idx, lat);
      chk({tag, " mem_en count"}, en_cnt[d], v.fault ? 0 : 1);
      chk({tag, " rsp count"}, rsp_cnt[d], 1);
      chk({tag, " rsp cycle"}, rsp_cyc[d], exp_rsp);
      chk({tag, " ready while busy"}, rdy_bad[d], 0);
      chk({tag, " misaligned"}, 32'(mis_s[d]), 32'(v.fault));
      chk({tag, " rsp_rdata"}, rd_s[d], v.rdata);
      chk({tag, " rsp_rdata held"}, rsp_rdata[d], v.rdata);
      if (!v.fault) begin
        chk({tag, " mem_en cycle"}, en_cyc[d], 1);
        chk({tag, " mem_be"}, 32'(be_s[d]), 32'(v.be));
        chk({tag, " mem_addr"}, 32'(ma_s[d]), 32'(v.maddr));
        chk({tag, " mem_we"}, 32'(we_s[d]), 32'(v.we));
        if (v.we) chk({tag, " mem_wdata"}, wd_s[d], v.mwdata);
      end
    end
    $display("vec %0d: we=%0b f3=%03b addr=%08h | lat1 rsp@%0d rdata=%08h mis=%0b | lat3 rsp@%0d rdata=%08h mis=%0b",
             idx, v.we, v.f3, v.addr, rsp_cyc[0], rd_s[0], mis_s[0], rsp_cyc[1], rd_s[1], mis_s[1]);
  endtask

  initial begin
    int cnt [2], first [2], second [2], bad [2];

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h80FF_1234;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'h7F00_8001;

    //           we  f3      addr          wdata         flt be       mwdata        maddr  rdata
    vecs[0]  = '{1, 3'b000, 32'h0000_0006, 32'h0000_00A5, 0, 4'b0100, 32'hA5A5_A5A5, 10'd1, 32'h0};
    vecs[1]  = '{0, 3'b000, 32'h0000_0003, 32'h0,         0, 4'b1000, 32'h0,         10'd0, 32'hFFFF_FF80};
    vecs[2]  = '{0, 3'b100, 32'h0000_0003, 32'h0,         0, 4'b1000, 32'h0,         10'd0, 32'h0000_0080};
    vecs[3]  = '{0, 3'b001, 32'h0000_0002, 32'h0,         0, 4'b1100, 32'h0,         10'd0, 32'hFFFF_80FF};
    vecs[4]  = '{0, 3'b101, 32'h0000_0002, 32'h0,         0, 4'b1100, 32'h0,         10'd0, 32'h0000_80FF};
    vecs[5]  = '{0, 3'b010, 32'h0000_0000, 32'h0,         0, 4'b1111, 32'h0,         10'd0, 32'h80FF_1234};
    vecs[6]  = '{1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D, 10'd2, 32'h0};
    vecs[7]  = '{0, 3'b010, 32'h0000_0002, 32'h0,         1, 4'b0000, 32'h0,         10'd0, 32'h0};
    vecs[8]  = '{0, 3'b011, 32'h0000_0000, 32'h0,         1, 4'b0000, 32'h0,         10'd0, 32'h0};
    vecs[9]  = '{1, 3'b001, 32'h0000_0006, 32'h1234_BEEF, 0, 4'b1100, 32'hBEEF_BEEF, 10'd1, 32'h0};
    vecs[10] = '{0, 3'b000, 32'h0000_0004, 32'h0,         0, 4'b0001, 32'h0,         10'd1, 32'h0000_0044};
    vecs[11] = '{0, 3'b000, 32'h0000_0009, 32'h0,         0, 4'b0010, 32'h0,         10'd2, 32'hFFFF_FF80};
    vecs[12] = '{0, 3'b001, 32'h0000_0008, 32'h0,         0, 4'b0011, 32'h0,         10'd2, 32'hFFFF_8001};
    vecs[13] = '{0, 3'b001, 32'h0000_0001, 32'h0,         1, 4'b0000, 32'h0,         10'd0, 32'h0};
    vecs[14] = '{1, 3'b100, 32'h0000_0000, 32'h0000_0055, 1, 4'b0000, 32'h0,         10'd0, 32'h0};
    vecs[15] = '{0, 3'b110, 32'h0000_0000, 32'h0,         1, 4'b0000, 32'h0,         10'd0, 32'h0};
    vecs[16] = '{0, 3'b111, 32'h0000_0000, 32'h0,         1, 4'b0000, 32'h0,         10'd0, 32'h0};
    vecs[17] = '{0, 3'b010, 32'hFFFF_F004, 32'h0,         0, 4'b1111, 32'h0,         10'd1, 32'h1122_3344};
    vecs[18] = '{0, 3'b100, 32'h0000_0007, 32'h0,         0, 4'b1000, 32'h0,         10'd1, 32'h0000_0011};
    vecs[19] = '{1, 3'b000, 32'h0000_0001, 32'hFFFF_FF3C, 0, 4'b0010, 32'h3C3C_3C3C, 10'd0, 32'h0};
    vecs[20] = '{1, 3'b001, 32'h0000_0003, 32'h0000_1111, 1, 4'b0000, 32'h0,         10'd0, 32'h0};
    vecs[21] = '{0, 3'b101, 32'h0000_000A, 32'h0,         0, 4'b1100, 32'h0,         10'd2, 32'h0000_7F00};

    // Reset state
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_funct3 = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset%0d ready", d), 32'(ready[d]), 32'd1);
      chk($sformatf("reset%0d rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("reset%0d misaligned", d), 32'(rsp_mis[d]), 32'd0);
      chk($sformatf("reset%0d rsp_rdata", d), rsp_rdata[d], 32'd0);
      chk($sformatf("reset%0d mem_en", d), 32'(mem_en[d]), 32'd0);
      chk($sformatf("reset%0d mem_we", d), 32'(mem_we[d]), 32'd0);
      chk($sformatf("reset%0d mem_addr", d), 32'(mem_addr[d]), 32'd0);
      chk($sformatf("reset%0d mem_be", d), 32'(mem_be[d]), 32'd0);
      chk($sformatf("reset%0d mem_wdata", d), mem_wdata[d], 32'd0);
    end
    rst = 1'b0;
    $display("reset: state checked on both controllers");

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Back-to-back: request held valid for 24 cycles
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_funct3 = 3'b010; req_wdata = '0;
    for (int d = 0; d < 2; d++) begin cnt[d] = 0; first[d] = 0; second[d] = 0; bad[d] = 0; end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d]) begin
          cnt[d]++;
          if (cnt[d] == 1) first[d] = k;
          if (cnt[d] == 2) second[d] = k;
          if (rsp_rdata[d] !== 32'h80FF_1234) bad[d]++;
        end
        if (ready[d] && (rsp_valid[d] || mem_en[d])) bad[d]++;
      end
      if (k == 24) req_valid = 1'b0;
    end
    n_vec++;
    chk("b2b lat1 count", cnt[0], 6);
    chk("b2b lat1 first", first[0], 3);
    chk("b2b lat1 second", second[0], 7);
    chk("b2b lat1 errors", bad[0], 0);
    chk("b2b lat3 count", cnt[1], 4);
    chk("b2b lat3 first", first[1], 5);
    chk("b2b lat3 second", second[1], 11);
    chk("b2b lat3 errors", bad[1], 0);
    $display("b2b: lat1 rsp=%0d first@%0d second@%0d | lat3 rsp=%0d first@%0d second@%0d",
             cnt[0], first[0], second[0], cnt[1], first[1], second[1]);
    repeat (2) @(negedge clk);

    // Reset while waiting for read data
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstwait lat1 mem_en", 32'(mem_en[0]), 32'd1);
    chk("rstwait lat3 mem_en", 32'(mem_en[1]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rstwait%0d ready", d), 32'(ready[d]), 32'd1);
      chk($sformatf("rstwait%0d mem_en", d), 32'(mem_en[d]), 32'd0);
      chk($sformatf("rstwait%0d rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("rstwait%0d rsp_rdata", d), rsp_rdata[d], 32'd0);
      bad[d] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (rsp_valid[d] || !ready[d]) bad[d]++;
    end
    n_vec++;
    chk("rstwait lat1 quiet", bad[0], 0);
    chk("rstwait lat3 quiet", bad[1], 0);
    $display("rstwait: aborted load, quiet cycles checked");
    run_vec(NV, '{0, 3'b010, 32'h0000_0004, 32'h0, 0, 4'b1111, 32'h0, 10'd1, 32'h1122_3344});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
